rx_depuncture_ctrl_wifi: RTL and testbench



---
 rtl/rx_wifi_pkg.sv | 18 +
 rtl/depunct_pattern_wifi.sv | 37 +++
 rtl/rx_depuncture_ctrl_wifi.sv | 99 +++++++++
 tb/tb_rx_depuncture_ctrl_wifi.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_wifi_pkg.sv
// Shared definitions for the WiFi RX depuncturing controller: rate codes,
// puncturing pattern periods and the controller state encoding.
package rx_wifi_pkg;

    localparam logic [1:0] RATE_12 = 2'b00;
    localparam logic [1:0] RATE_23 = 2'b01;
    localparam logic [1:0] RATE_34 = 2'b10;

    localparam logic [2:0] PERIOD_12 = 3'd2;
    localparam logic [2:0] PERIOD_23 = 3'd4;
    localparam logic [2:0] PERIOD_34 = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/depunct_pattern_wifi.sv
// Combinational 802.11a/g puncturing pattern lookup: (rate, pos) -> erasure slot
// and end-of-period flags. Rate 2/3 decode exists only with RX_DEPUNCT_RATE23_EN.
module depunct_pattern_wifi
    import rx_wifi_pkg::*;
(
    input  logic [1:0] rate,
    input  logic [2:0] pos,
    output logic       insert,
    output logic       last_pos
);

    logic [2:0] period;

    // Reserved rate 11 (and 01 when 2/3 is not built) fall back to plain 1/2.
    always_comb begin
        period = PERIOD_12;
        insert = 1'b0;
        case (rate)
`ifdef RX_DEPUNCT_RATE23_EN
            RATE_23: begin
                period = PERIOD_23;
                insert = (pos == 3'd3);
            end
`endif
            RATE_34: begin
                period = PERIOD_34;
                insert = (pos == 3'd3) || (pos == 3'd4);
            end
            default: begin
                period = PERIOD_12;
                insert = 1'b0;
            end
        endcase
        last_pos = (pos == (period - 3'd1));
    end

endmodule

// File: rtl/rx_depuncture_ctrl_wifi.sv
// Depuncturing sequencer ahead of the Viterbi decoder: re-inserts erasure slots
// and counts mother-code bits per frame. Optional rate 2/3: RX_DEPUNCT_RATE23_EN.
module rx_depuncture_ctrl_wifi
    import rx_wifi_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       rate,
    input  logic [LEN_W-1:0] n_bits,
    input  logic             valid_in,
    input  logic             data_in,
    output logic             in_ready,
    output logic             valid_out,
    output logic             data_out,
    output logic             erase_out,
    output logic             busy,
    output logic             finished,
    output state_e           dbg_state
);

    state_e           state, state_d;
    logic [1:0]       rate_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic [2:0]       pos;
    logic             insert, last_pos;
    logic             issue, is_last;
    logic             start_ok, zero_len;

    depunct_pattern_wifi u_pattern (
        .rate     (rate_q),
        .pos      (pos),
        .insert   (insert),
        .last_pos (last_pos)
    );

    assign cnt_inc  = cnt + LEN_W'(1);
    assign start_ok = (state == ST_IDLE) && start;
    assign zero_len = (n_bits == '0);

    // Handshake: a bit is consumed from data_in only in a cycle where valid_in
    // and in_ready are both high; in_ready never depends on valid_in.
    assign in_ready  = (state == ST_RUN) && !insert;
    assign dbg_state = state;

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        is_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !zero_len) state_d = ST_RUN;
            end
            ST_RUN: begin
                issue   = insert || valid_in;
                is_last = issue && (cnt_inc == len_q);
                if (is_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rate_q    <= RATE_12;
            len_q     <= '0;
            cnt       <= '0;
            pos       <= '0;
            valid_out <= 1'b0;
            data_out  <= 1'b0;
            erase_out <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            state     <= state_d;
            valid_out <= issue;
            data_out  <= issue && !insert && data_in;
            erase_out <= issue && insert;
            finished  <= is_last || (start_ok && zero_len);
            // Holds through the finished cycle so busy falls one cycle after it.
            busy      <= (state == ST_RUN) || (state_d == ST_RUN);
            if (start_ok) begin
                rate_q <= rate;
                len_q  <= n_bits;
                cnt    <= '0;
                pos    <= '0;
            end else if (issue) begin
                cnt <= cnt_inc;
                pos <= last_pos ? 3'd0 : (pos + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_rx_depuncture_ctrl_wifi.sv
// Self-checking bench for rx_depuncture_ctrl_wifi: table of frames with expected
// output patterns, a queue scoreboard on valid_out and hand-written corner sequences.
module tb_rx_depuncture_ctrl_wifi;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       rate;
    logic [LEN_W-1:0] n_bits;
    logic             valid_in;
    logic             data_in;
    logic             in_ready;
    logic             valid_out;
    logic             data_out;
    logic             erase_out;
    logic             busy;
    logic             finished;
    rx_wifi_pkg::state_e dbg_state;

    typedef struct {
        logic [1:0]  rate;
        logic [15:0] n;
        logic [15:0] din;
        int          vmode;
        logic [15:0] exp_d;
        logic [15:0] exp_e;
        int          exp_rdy_low;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q[$];
    int         out_cnt = 0;
    logic       fin_seen = 1'b0;
    logic       zero_len_ok = 1'b0;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    rx_depuncture_ctrl_wifi #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rate      (rate),
        .n_bits    (n_bits),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .erase_out (erase_out),
        .busy      (busy),
        .finished  (finished),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled just after the active edge.
    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        if (reset) begin
            if (valid_out) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_out", valid_out, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", data_out, e[2]);
                    check("erase_out", erase_out, e[1]);
                    check("finished", finished, e[0]);
                    if (finished) fin_seen = 1'b1;
                end
            end else if (finished && !zero_len_ok) begin
                check("stray_finished", finished, 1'b0);
            end
        end
    end

    task automatic run_frame(input vec_t v, input int abort_after);
        int   idx = 0;
        int   rdy_low = 0;
        int   cyc = 0;
        logic rdy;
        logic f;
        for (int i = 0; i < int'(v.n); i++) begin
            f = (i == int'(v.n) - 1);
            exp_q.push_back({v.exp_d[15-i], v.exp_e[15-i], f});
        end
        fin_seen = 1'b0;
        out_cnt  = 0;
        @(negedge clk);
        start    = 1'b1;
        rate     = v.rate;
        n_bits   = v.n;
        valid_in = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        rate   = 2'($urandom_range(0, 3));
        n_bits = 16'($urandom);
        check("busy_after_start", busy, 1'b1);
        check("state_run", 32'(dbg_state), 32'(rx_wifi_pkg::ST_RUN));
        while (!fin_seen && cyc < 200 && !(abort_after > 0 && out_cnt >= abort_after)) begin
            case (v.vmode)
                0:       valid_in = 1'b1;
                1:       valid_in = (cyc % 2 == 0);
                default: valid_in = ($urandom_range(0, 3) != 0);
            endcase
            data_in = (valid_in && idx < 16) ? v.din[15-idx] : 1'($urandom_range(0, 1));
            // A start mid-frame with different parameters must be ignored.
            if (cyc == 2) begin
                start  = 1'b1;
                rate   = 2'b00;
                n_bits = 16'd3;
            end else begin
                start = 1'b0;
            end
            rdy = in_ready;
            if (!rdy) rdy_low++;
            @(posedge clk);
            if (valid_in && rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        valid_in = 1'b0;
        start    = 1'b0;
        if (abort_after > 0) begin
            reset = 1'b0;
            #1;
            check("rst_valid_out", valid_out, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_finished", finished, 1'b0);
            check("rst_in_ready", in_ready, 1'b0);
            exp_q.delete();
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("post_rst_valid_out", valid_out, 1'b0);
        end else begin
            check("frame_done", fin_seen, 1'b1);
            check("exp_q_empty", exp_q.size(), 0);
            check("in_ready_low_cycles", rdy_low, v.exp_rdy_low);
            check("busy_in_finished_cycle", busy, 1'b1);
            check("in_ready_after_frame", in_ready, 1'b0);
            exp_q.delete();
            @(negedge clk);
            check("busy_dropped", busy, 1'b0);
            check("finished_one_cycle", finished, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{2'b00, 16'd8,  16'b1011_0010_0000_0000, 0,
                    16'b1011_0010_0000_0000, 16'b0, 0};
        vecs[1] = '{2'b10, 16'd12, 16'b1111_0101_0000_0000, 0,
                    16'b1110_0101_0001_0000, 16'b0001_1000_0110_0000, 4};
`ifdef RX_DEPUNCT_RATE23_EN
        vecs[2] = '{2'b01, 16'd8,  16'b1010_1101_0000_0000, 1,
                    16'b1010_0110_0000_0000, 16'b0001_0001_0000_0000, 2};
        vecs[3] = '{2'b01, 16'd4,  16'b1101_0000_0000_0000, 0,
                    16'b1100_0000_0000_0000, 16'b0001_0000_0000_0000, 1};
`else
        vecs[2] = '{2'b01, 16'd8,  16'b1010_1101_0000_0000, 1,
                    16'b1010_1101_0000_0000, 16'b0, 0};
        vecs[3] = '{2'b01, 16'd4,  16'b1101_0000_0000_0000, 0,
                    16'b1101_0000_0000_0000, 16'b0, 0};
`endif
        vecs[4] = '{2'b11, 16'd6,  16'b0110_1100_0000_0000, 2,
                    16'b0110_1100_0000_0000, 16'b0, 0};
        vecs[5] = '{2'b10, 16'd10, 16'b1011_0010_0000_0000, 2,
                    16'b1010_0100_1000_0000, 16'b0001_1000_0100_0000, 3};

        reset    = 1'b0;
        start    = 1'b0;
        rate     = 2'b00;
        n_bits   = '0;
        valid_in = 1'b0;
        data_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_valid_out", valid_out, 1'b0);
        check("reset_data_out", data_out, 1'b0);
        check("reset_erase_out", erase_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_finished", finished, 1'b0);
        check("reset_state", 32'(dbg_state), 32'(rx_wifi_pkg::ST_IDLE));
        reset = 1'b1;

        // valid_in while idle is not consumed and produces nothing.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = 1'b1;
            check("idle_in_ready", in_ready, 1'b0);
            check("idle_valid_out", valid_out, 1'b0);
        end
        valid_in = 1'b0;

        // Zero-length frame: finished next cycle, no output, never busy.
        zero_len_ok = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        n_bits = '0;
        rate   = 2'b10;
        @(negedge clk);
        start = 1'b0;
        check("zero_len_finished", finished, 1'b1);
        check("zero_len_valid_out", valid_out, 1'b0);
        check("zero_len_busy", busy, 1'b0);
        @(negedge clk);
        check("zero_len_finished_pulse", finished, 1'b0);
        check("zero_len_busy_after", busy, 1'b0);
        zero_len_ok = 1'b0;

        for (int k = 0; k < 6; k++) run_frame(vecs[k], 0);

        // Reset after 5 outputs of a 3/4 frame, then the same frame in full.
        run_frame(vecs[5], 5);
        run_frame(vecs[5], 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
